// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM (addi/lw/bne); optional instret via MULTICYCLE_CTRL_INSTRET_EN
module multicycle_ctrl #(
    parameter int OPCODE_WIDTH  = 7,
    parameter int ALUCTRL_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [OPCODE_WIDTH-1:0]  opcode,
    input  logic [2:0]               funct3,
    input  logic                     EQ,
    input  logic                     instr_valid,
    input  logic                     mem_ready,
    output logic                     instr_req,
    output logic                     ir_we,
    output logic                     ImmSrc,
    output logic                     ALUsrc,
    output logic [ALUCTRL_WIDTH-1:0] ALUctrl,
    output logic                     RegWrite,
    output logic                     ResultSrc,
    output logic                     mem_req,
    output logic                     PCsrc,
    output logic                     pc_we,
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    output logic [31:0]              instret,
`endif
    output logic                     trap,
    output logic                     busy
);

    localparam logic [OPCODE_WIDTH-1:0]  OPC_OP_IMM = OPCODE_WIDTH'(7'b0010011);
    localparam logic [OPCODE_WIDTH-1:0]  OPC_LOAD   = OPCODE_WIDTH'(7'b0000011);
    localparam logic [OPCODE_WIDTH-1:0]  OPC_BRANCH = OPCODE_WIDTH'(7'b1100011);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD    = ALUCTRL_WIDTH'(0);
    localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB    = ALUCTRL_WIDTH'(1);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC_ALU, EXEC_BR, MEM_ADDR, MEM_WAIT, WB, TRAP
    } state_t;

    state_t state_q, state_d;

    logic is_addi, is_lw, is_bne;
    assign is_addi = (opcode == OPC_OP_IMM) && (funct3 == 3'b000);
    assign is_lw   = (opcode == OPC_LOAD)   && (funct3 == 3'b010);
    assign is_bne  = (opcode == OPC_BRANCH) && (funct3 == 3'b001);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_req = 1'b0;
        ir_we     = 1'b0;
        ImmSrc    = 1'b0;
        ALUsrc    = 1'b0;
        ALUctrl   = ALU_ADD;
        RegWrite  = 1'b0;
        ResultSrc = 1'b0;
        mem_req   = 1'b0;
        PCsrc     = 1'b0;
        pc_we     = 1'b0;
        trap      = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            FETCH: begin
                busy      = 1'b0;
                instr_req = 1'b1;
                if (instr_valid) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ImmSrc = is_addi || is_lw;
                if (is_addi)     state_d = EXEC_ALU;
                else if (is_lw)  state_d = MEM_ADDR;
                else if (is_bne) state_d = EXEC_BR;
                else             state_d = TRAP;
            end
            EXEC_ALU: begin
                ImmSrc  = 1'b1;
                ALUsrc  = 1'b1;
                state_d = WB;
            end
            EXEC_BR: begin
                ALUctrl = ALU_SUB;
                pc_we   = 1'b1;
                PCsrc   = ~EQ;
                state_d = FETCH;
            end
            MEM_ADDR: begin
                ImmSrc  = 1'b1;
                ALUsrc  = 1'b1;
                mem_req = 1'b1;
                state_d = MEM_WAIT;
            end
            // Address operands stay selected so the memory sees a stable address.
            MEM_WAIT: begin
                ImmSrc  = 1'b1;
                ALUsrc  = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) state_d = WB;
            end
            WB: begin
                RegWrite  = 1'b1;
                pc_we     = 1'b1;
                ResultSrc = (opcode == OPC_LOAD);
                state_d   = FETCH;
            end
            TRAP: begin
                busy = 1'b0;
                trap = 1'b1;
            end
            default: state_d = TRAP;
        endcase
    end

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [31:0] instret_q, instret_d;

    assign instret_d = pc_we ? instret_q + 32'd1 : instret_q;
    assign instret   = instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= 32'd0;
        end else begin
            instret_q <= instret_d;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       EQ, instr_valid, mem_ready;
    logic       instr_req, ir_we, ImmSrc, ALUsrc, RegWrite, ResultSrc;
    logic       mem_req, PCsrc, pc_we, trap, busy;
    logic [2:0] ALUctrl;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
    logic [31:0] instret;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct3      (funct3),
        .EQ          (EQ),
        .instr_valid (instr_valid),
        .mem_ready   (mem_ready),
        .instr_req   (instr_req),
        .ir_we       (ir_we),
        .ImmSrc      (ImmSrc),
        .ALUsrc      (ALUsrc),
        .ALUctrl     (ALUctrl),
        .RegWrite    (RegWrite),
        .ResultSrc   (ResultSrc),
        .mem_req     (mem_req),
        .PCsrc       (PCsrc),
        .pc_we       (pc_we),
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        .instret     (instret),
`endif
        .trap        (trap),
        .busy        (busy)
    );

    // Field order: instr_req ir_we ImmSrc ALUsrc ALUctrl RegWrite ResultSrc mem_req PCsrc pc_we trap busy
    localparam logic [13:0] F_IDLE = 14'b1_0_0_0_000_0_0_0_0_0_0_0;
    localparam logic [13:0] F_VAL  = 14'b1_1_0_0_000_0_0_0_0_0_0_0;
    localparam logic [13:0] DEC_I  = 14'b0_0_1_0_000_0_0_0_0_0_0_1;
    localparam logic [13:0] DEC_B  = 14'b0_0_0_0_000_0_0_0_0_0_0_1;
    localparam logic [13:0] EX_ALU = 14'b0_0_1_1_000_0_0_0_0_0_0_1;
    localparam logic [13:0] BR_T   = 14'b0_0_0_0_001_0_0_0_1_1_0_1;
    localparam logic [13:0] BR_NT  = 14'b0_0_0_0_001_0_0_0_0_1_0_1;
    localparam logic [13:0] MEM    = 14'b0_0_1_1_000_0_0_1_0_0_0_1;
    localparam logic [13:0] WB_A   = 14'b0_0_0_0_000_1_0_0_0_1_0_1;
    localparam logic [13:0] WB_L   = 14'b0_0_0_0_000_1_1_0_0_1_0_1;
    localparam logic [13:0] TRP    = 14'b0_0_0_0_000_0_0_0_0_0_1_0;

    logic [13:0] outs;
    assign outs = {instr_req, ir_we, ImmSrc, ALUsrc, ALUctrl, RegWrite, ResultSrc,
                   mem_req, PCsrc, pc_we, trap, busy};

    task automatic ex(input string tag, input logic [13:0] exp);
        #1;
        total++;
        assert (outs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
        end
    endtask

`ifdef MULTICYCLE_CTRL_INSTRET_EN
    task automatic ex_ir(input string tag, input logic [31:0] exp);
        #1;
        total++;
        assert (instret === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, instret, exp);
        end
    endtask
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [6:0] op, input logic [2:0] f3);
        opcode = op; funct3 = f3; instr_valid = 1'b1;
        ex("fetch_valid", F_VAL);
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct3 = '0; EQ = 1'b0;
        instr_valid = 1'b0; mem_ready = 1'b0;
        repeat (3) step();
        ex("reset_state", F_IDLE);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        ex_ir("instret_reset", 32'd0);
`endif
        rst_n = 1'b1;

        // addi: FETCH, DECODE, EXEC_ALU, WB, FETCH
        start(7'b0010011, 3'b000);
        ex("addi_decode", DEC_I);  step();
        ex("addi_exec", EX_ALU);   step();
        ex("addi_wb", WB_A);       step();
        ex("addi_done", F_IDLE);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        ex_ir("instret_addi", 32'd1);
`endif

        // bne taken then not taken
        EQ = 1'b0;
        start(7'b1100011, 3'b001);
        ex("bne_decode", DEC_B);   step();
        ex("bne_taken", BR_T);     step();
        ex("bne_t_done", F_IDLE);
        EQ = 1'b1;
        start(7'b1100011, 3'b001);
        ex("bne_decode2", DEC_B);  step();
        ex("bne_not_taken", BR_NT); step();
        ex("bne_nt_done", F_IDLE);
        EQ = 1'b0;
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        ex_ir("instret_bne", 32'd3);
`endif

        // lw: mem_ready high in MEM_ADDR must be ignored, then 3 wait cycles
        start(7'b0000011, 3'b010);
        ex("lw_decode", DEC_I);    step();
        mem_ready = 1'b1;
        ex("lw_mem_addr", MEM);    step();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex($sformatf("lw_wait%0d", i), MEM);
            step();
        end
        mem_ready = 1'b1;
        ex("lw_wait_ready", MEM);  step();
        mem_ready = 1'b0;
        ex("lw_wb", WB_L);         step();
        ex("lw_done", F_IDLE);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        ex_ir("instret_lw", 32'd4);
`endif

        // fetch stall
        for (int i = 0; i < 5; i++) begin
            ex($sformatf("stall%0d", i), F_IDLE);
            step();
        end

        // reset during MEM_WAIT aborts with no RegWrite/pc_we
        start(7'b0000011, 3'b010);
        ex("lw2_decode", DEC_I);   step();
        ex("lw2_mem_addr", MEM);   step();
        ex("lw2_wait", MEM);
        rst_n = 1'b0;
        ex("abort_immediate", F_IDLE);
        mem_ready = 1'b1;
        step();
        ex("abort_hold", F_IDLE);
`ifdef MULTICYCLE_CTRL_INSTRET_EN
        ex_ir("instret_abort", 32'd0);
`endif
        mem_ready = 1'b0;
        rst_n = 1'b1;
        step();
        ex("abort_release", F_IDLE);

        // illegal opcode traps until reset
        start(7'b0110111, 3'b000);
        ex("illegal_decode", DEC_B); step();
        instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ex($sformatf("trap%0d", i), TRP);
            step();
        end
        instr_valid = 1'b0;
        rst_n = 1'b0;
        ex("trap_reset", F_IDLE);
        step();
        rst_n = 1'b1;
        step();
        ex("trap_cleared", F_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
